// File: rtl/fifo_wr_packer_if.sv
// fifo_wr_packer_if: producer beat stream plus FIFO write port
// for the write-side packer of the async FIFO.
interface fifo_wr_packer_if #(
   parameter int InWidth = 8,
   parameter int Ratio   = 4
);
   localparam int CntWidth  = $clog2(Ratio);
   localparam int FifoWidth = 1 + CntWidth + Ratio * InWidth;

   logic                 s_valid;
   logic                 s_ready;
   logic [InWidth-1:0]   s_data;
   logic                 s_last;
   logic                 wr_full;
   logic                 wr_req;
   logic [FifoWidth-1:0] wr_data;
   logic                 busy;

   // Packer side: consumes beats, produces FIFO writes.
   modport slave (
      input  s_valid,
      input  s_data,
      input  s_last,
      input  wr_full,
      output s_ready,
      output wr_req,
      output wr_data,
      output busy
   );

   // Environment side: producer and write-pointer logic.
   modport master (
      output s_valid,
      output s_data,
      output s_last,
      output wr_full,
      input  s_ready,
      input  wr_req,
      input  wr_data,
      input  busy
   );
endinterface

// File: rtl/fifo_wr_packer.sv
// fifo_wr_packer: packs Ratio narrow beats into one wide FIFO word
// {last, beats-1, lanes}; writes only while wr_full is low.
module fifo_wr_packer #(
   parameter int InWidth = 8,
   parameter int Ratio   = 4
) (
   input  logic wr_clk,
   input  logic wr_rst_n,
   fifo_wr_packer_if.slave bus
);
   localparam int CntWidth  = $clog2(Ratio);
   localparam int LaneBits  = Ratio * InWidth;
   localparam int FifoWidth = 1 + CntWidth + LaneBits;
   localparam logic [CntWidth-1:0] LastLane = CntWidth'(Ratio - 1);

   logic [CntWidth-1:0]  r_acc_cnt;
   logic [LaneBits-1:0]  r_acc_data;
   logic                 r_out_valid;
   logic [FifoWidth-1:0] r_out_data;

   logic                 w_drain;
   logic                 w_ready;
   logic                 w_accept;
   logic                 w_close;
   logic [LaneBits-1:0]  w_lanes;
   logic [LaneBits-1:0]  w_acc_ins;

   // The holding register drains whenever the FIFO has room; a
   // beat may enter if the holding register is empty or draining.
   assign w_drain  = r_out_valid & ~bus.wr_full;
   assign w_ready  = ~r_out_valid | ~bus.wr_full;
   assign w_accept = bus.s_valid & w_ready;
   assign w_close  = w_accept &
                     ((r_acc_cnt == LastLane) | bus.s_last);

   // Closing word: lanes below the cursor keep accumulated beats,
   // the cursor lane takes s_data, lanes above are forced to zero.
   always_comb begin
      w_lanes   = '0;
      w_acc_ins = r_acc_data;
      for (int i = 0; i < Ratio; i++) begin
         if (CntWidth'(i) < r_acc_cnt) begin
            w_lanes[i*InWidth +: InWidth] =
               r_acc_data[i*InWidth +: InWidth];
         end else if (CntWidth'(i) == r_acc_cnt) begin
            w_lanes[i*InWidth +: InWidth]   = bus.s_data;
            w_acc_ins[i*InWidth +: InWidth] = bus.s_data;
         end
      end
   end

   // Accumulator: collect beats until the word closes, then clear.
   always_ff @(posedge wr_clk or negedge wr_rst_n) begin
      if (!wr_rst_n) begin
         r_acc_cnt  <= '0;
         r_acc_data <= '0;
      end else if (w_close) begin
         r_acc_cnt  <= '0;
         r_acc_data <= '0;
      end else if (w_accept) begin
         r_acc_cnt  <= r_acc_cnt + 1'b1;
         r_acc_data <= w_acc_ins;
      end
   end

   // Output holding register: a reload wins over a drain so that a
   // simultaneous write and close keeps the stream bubble-free.
   always_ff @(posedge wr_clk or negedge wr_rst_n) begin
      if (!wr_rst_n) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else if (w_close) begin
         r_out_valid <= 1'b1;
         r_out_data  <= {bus.s_last, r_acc_cnt, w_lanes};
      end else if (w_drain) begin
         r_out_valid <= 1'b0;
      end
   end

   assign bus.s_ready = w_ready;
   assign bus.wr_req  = w_drain;
   assign bus.wr_data = r_out_data;
   assign bus.busy    = r_out_valid | (r_acc_cnt != '0);

endmodule

// File: tb/tb_fifo_wr_packer.sv
// tb_fifo_wr_packer: directed vector table, reset and drain/reload
// sequences, and a randomised wr_full run against a packing model.
module tb_fifo_wr_packer;
   localparam int IW = 8;
   localparam int RT = 4;
   localparam int FW = 35;

   typedef struct {
      logic          v;
      logic [IW-1:0] d;
      logic          l;
      logic          f;
      logic          e_rdy;
      logic          e_req;
      logic          e_busy;
      logic [FW-1:0] e_data;
   } vec_t;

   localparam logic [FW-1:0] W0 = '0;
   localparam logic [FW-1:0] W1 = {1'b1, 2'b11, 32'h44332211};
   localparam logic [FW-1:0] W2 = {1'b1, 2'b01, 32'h0000BBAA};
   localparam logic [FW-1:0] W3 = {1'b0, 2'b11, 32'h04030201};
   localparam logic [FW-1:0] W4 = {1'b0, 2'b11, 32'h08070605};
   localparam logic [FW-1:0] W5 = {1'b1, 2'b00, 32'h0000005A};
   localparam logic [FW-1:0] W6 = {1'b1, 2'b01, 32'h00007799};
   localparam logic [FW-1:0] W7 = {1'b1, 2'b00, 32'h00000033};
   localparam logic [FW-1:0] W8 = {1'b1, 2'b01, 32'h00003412};
   localparam logic [FW-1:0] W9 = {1'b1, 2'b11, 32'h60504030};

   logic wr_clk;
   logic wr_rst_n;
   int   n_cmp;
   int   n_bad;

   fifo_wr_packer_if #(.InWidth(IW), .Ratio(RT)) bus ();

   fifo_wr_packer #(.InWidth(IW), .Ratio(RT)) dut (
      .wr_clk   (wr_clk),
      .wr_rst_n (wr_rst_n),
      .bus      (bus.slave)
   );

   initial wr_clk = 1'b0;
   always #5 wr_clk = ~wr_clk;

   task automatic chk(input string nm, input logic [FW-1:0] act,
                      input logic [FW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp,
                  $time);
      end
   endtask

   task automatic run_vec(input vec_t x, input int idx);
      @(negedge wr_clk);
      bus.s_valid = x.v;
      bus.s_data  = x.d;
      bus.s_last  = x.l;
      bus.wr_full = x.f;
      #1;
      chk($sformatf("v%0d.s_ready", idx), FW'(bus.s_ready),
          FW'(x.e_rdy));
      chk($sformatf("v%0d.wr_req", idx), FW'(bus.wr_req),
          FW'(x.e_req));
      chk($sformatf("v%0d.busy", idx), FW'(bus.busy),
          FW'(x.e_busy));
      chk($sformatf("v%0d.wr_data", idx), bus.wr_data, x.e_data);
   endtask

   function automatic vec_t mk(logic v, logic [IW-1:0] d, logic l,
                               logic f, logic r, logic q, logic b,
                               logic [FW-1:0] w);
      vec_t x;
      x.v = v; x.d = d; x.l = l; x.f = f;
      x.e_rdy = r; x.e_req = q; x.e_busy = b; x.e_data = w;
      return x;
   endfunction

   vec_t            tbl[$];
   logic [FW-1:0]   exp_q[$];
   logic [4*IW-1:0] m_lanes;
   int              m_cnt;

   initial begin
      n_cmp = 0;
      n_bad = 0;
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      bus.s_last  = 1'b0;
      bus.wr_full = 1'b0;
      wr_rst_n    = 1'b0;

      // v  d     l  f  rdy req busy data
      // 1: full four-beat word with last
      tbl.push_back(mk(1, 8'h11, 0, 0, 1, 0, 0, W0));
      tbl.push_back(mk(1, 8'h22, 0, 0, 1, 0, 1, W0));
      tbl.push_back(mk(1, 8'h33, 0, 0, 1, 0, 1, W0));
      tbl.push_back(mk(1, 8'h44, 1, 0, 1, 0, 1, W0));
      tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1, 1, W1));
      tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, W1));
      // 2: short packet
      tbl.push_back(mk(1, 8'hAA, 0, 0, 1, 0, 0, W1));
      tbl.push_back(mk(1, 8'hBB, 1, 0, 1, 0, 1, W1));
      tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1, 1, W2));
      tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, W2));
      // 3: continuous stream, no last
      tbl.push_back(mk(1, 8'h01, 0, 0, 1, 0, 0, W2));
      tbl.push_back(mk(1, 8'h02, 0, 0, 1, 0, 1, W2));
      tbl.push_back(mk(1, 8'h03, 0, 0, 1, 0, 1, W2));
      tbl.push_back(mk(1, 8'h04, 0, 0, 1, 0, 1, W2));
      tbl.push_back(mk(1, 8'h05, 0, 0, 1, 1, 1, W3));
      tbl.push_back(mk(1, 8'h06, 0, 0, 1, 0, 1, W3));
      tbl.push_back(mk(1, 8'h07, 0, 0, 1, 0, 1, W3));
      tbl.push_back(mk(1, 8'h08, 0, 0, 1, 0, 1, W3));
      tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1, 1, W4));
      tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, W4));
      // 4: pending word held under wr_full for 5 cycles
      tbl.push_back(mk(1, 8'h5A, 1, 0, 1, 0, 0, W4));
      for (int i = 0; i < 5; i++)
         tbl.push_back(mk(1, 8'h99, 0, 1, 0, 0, 1, W5));
      tbl.push_back(mk(1, 8'h99, 0, 0, 1, 1, 1, W5));
      // drain and reload in the same cycle, no bubble
      tbl.push_back(mk(1, 8'h77, 1, 0, 1, 0, 1, W5));
      tbl.push_back(mk(1, 8'h33, 1, 0, 1, 1, 1, W6));
      tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1, 1, W7));
      tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, W7));
      // full with empty holding register still accepts
      tbl.push_back(mk(1, 8'h12, 0, 1, 1, 0, 0, W7));
      tbl.push_back(mk(0, 8'h00, 0, 1, 1, 0, 1, W7));
      tbl.push_back(mk(1, 8'h34, 1, 1, 1, 0, 1, W7));
      tbl.push_back(mk(1, 8'h55, 0, 1, 0, 0, 1, W8));
      tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1, 1, W8));
      tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, W8));

      repeat (3) @(posedge wr_clk);
      #1;
      chk("rst.wr_req", FW'(bus.wr_req), FW'(0));
      chk("rst.busy", FW'(bus.busy), FW'(0));
      chk("rst.wr_data", bus.wr_data, W0);
      @(negedge wr_clk);
      wr_rst_n = 1'b1;

      foreach (tbl[i]) run_vec(tbl[i], i);

      // 5: reset mid-operation discards the partial word
      run_vec(mk(1, 8'h10, 0, 0, 1, 0, 0, W8), 100);
      run_vec(mk(1, 8'h20, 0, 0, 1, 0, 1, W8), 101);
      @(negedge wr_clk);
      bus.s_valid = 1'b0;
      wr_rst_n    = 1'b0;
      #1;
      chk("mrst.wr_req", FW'(bus.wr_req), FW'(0));
      chk("mrst.busy", FW'(bus.busy), FW'(0));
      chk("mrst.wr_data", bus.wr_data, W0);
      #2;
      wr_rst_n = 1'b1;
      run_vec(mk(1, 8'h30, 0, 0, 1, 0, 0, W0), 102);
      run_vec(mk(1, 8'h40, 0, 0, 1, 0, 1, W0), 103);
      run_vec(mk(1, 8'h50, 0, 0, 1, 0, 1, W0), 104);
      run_vec(mk(1, 8'h60, 1, 0, 1, 0, 1, W0), 105);
      run_vec(mk(0, 8'h00, 0, 0, 1, 1, 1, W9), 106);
      run_vec(mk(0, 8'h00, 0, 0, 1, 0, 0, W9), 107);

      // 6: random wr_full against a packing scoreboard
      m_lanes = '0;
      m_cnt   = 0;
      for (int c = 0; c < 600; c++) begin
         @(negedge wr_clk);
         bus.wr_full = ($urandom_range(0, 2) == 0);
         bus.s_valid = ($urandom_range(0, 3) != 0);
         bus.s_data  = 8'($urandom);
         bus.s_last  = ($urandom_range(0, 5) == 0);
         #1;
         chk("rnd.req_while_full",
             FW'(bus.wr_req & bus.wr_full), FW'(0));
         if (bus.wr_req) begin
            if (exp_q.size() == 0) begin
               chk("rnd.unexpected_word", bus.wr_data, W0 - 1);
            end else begin
               chk("rnd.word", bus.wr_data, exp_q.pop_front());
            end
         end
         if (bus.s_valid && bus.s_ready) begin
            m_lanes[m_cnt*IW +: IW] = bus.s_data;
            if (m_cnt == RT - 1 || bus.s_last) begin
               exp_q.push_back({bus.s_last, 2'(m_cnt), m_lanes});
               m_lanes = '0;
               m_cnt   = 0;
            end else begin
               m_cnt++;
            end
         end
      end
      @(negedge wr_clk);
      bus.s_valid = 1'b0;
      bus.wr_full = 1'b0;
      for (int c = 0; c < 10; c++) begin
         #1;
         if (bus.wr_req) begin
            if (exp_q.size() == 0) begin
               chk("drn.unexpected_word", bus.wr_data, W0 - 1);
            end else begin
               chk("drn.word", bus.wr_data, exp_q.pop_front());
            end
         end
         @(negedge wr_clk);
      end
      chk("drn.left_in_queue", FW'(exp_q.size()), FW'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/fifo_wr_packer.md
Name: fifo_wr_packer

Overview:
Write-side ingress stage for the async FIFO. It sits directly upstream of the write-pointer/full-flag logic and the dual-port memory, in the write clock domain. It accepts narrow beats from a valid/ready producer and packs Ratio beats into one wide FIFO word, with a word-level last flag and a valid-beat count. It issues wr_req only when the registered wr_full flag is deasserted, so no write is ever attempted into a full FIFO.

Parameters:
InWidth, 8, width of one input beat in bits
Ratio, 4, input beats per FIFO word; power of two, minimum 2
CntWidth, clog2(Ratio), width of the valid-beat-count field (localparam)
FifoWidth, 1+CntWidth+Ratio*InWidth, FIFO word width (localparam)

Ports:
wr_clk  input  1  write-domain clock
wr_rst_n  input  1  asynchronous active-low reset
s_valid  input  1  input beat valid
s_ready  output  1  input beat accepted when s_valid & s_ready
s_data  input  InWidth  input beat payload
s_last  input  1  beat closes the current word and marks end of packet
wr_full  input  1  FIFO full flag from the write-pointer logic, registered in wr_clk
wr_req  output  1  write request to the write-pointer logic and memory write enable
wr_data  output  FifoWidth  packed word: {last, beats-1, lanes}
busy  output  1  accumulator or output register holds data

Behaviour:
- Reset (wr_rst_n low, asynchronous): acc_cnt=0, acc_data=0, out_valid=0, out_data=0. Outputs: wr_req=0, wr_data=0, busy=0, s_ready=1 once reset is released.
- Storage: one accumulator (acc_data with Ratio lanes, acc_cnt 0..Ratio-1) plus one output holding register (out_valid, out_data).
- Drain: wr_req = out_valid & ~wr_full. wr_data = out_data, held stable while out_valid=1. When wr_req=1, out_valid clears at the next edge unless it is reloaded in the same cycle.
- Input ready: s_ready = ~out_valid | ~wr_full. This depends only on registers and wr_full, with no combinational path from s_valid or s_last.
- Accept, beat not closing the word (acc_cnt<Ratio-1 and s_last=0):
  - s_data is written into lane acc_cnt.
  - acc_cnt increments.
- Accept, beat closing the word (acc_cnt==Ratio-1 or s_last=1):
  - out_data <= {s_last, acc_cnt, lanes}, where lanes = acc_data with lane acc_cnt replaced by s_data and all lanes above acc_cnt forced to zero.
  - out_valid <= 1.
  - acc_cnt <= 0; acc_data <= 0.
- Lane order: beat 0 occupies the LSBs (wr_data[InWidth-1:0]).
- Count field: wr_data[FifoWidth-2 -: CntWidth] = number of valid beats minus 1.
- Latency: a word closes on the accept edge at cycle n. wr_req is high in cycle n+1 if wr_full=0.
- Simultaneous drain and reload: when out_valid=1, wr_full=0 and a closing beat is accepted in the same cycle, the old word is written and the new word is loaded. out_valid stays 1, with no bubble.
- Full back-pressure: with out_valid=1 and wr_full=1, s_ready=0 and no beat is accepted, even a non-closing one. wr_req=0 and out_data is held. Writing resumes in the first cycle wr_full drops.
- Throughput: with wr_full=0, one beat is accepted per cycle. Sustained rate is one word per Ratio cycles.
- busy = out_valid | (acc_cnt!=0).
- Reset mid-operation: a partial accumulator and any pending output word are discarded. The next accepted beat lands in lane 0.
- s_valid is not required to stay asserted when s_ready=0; unaccepted beats have no effect.

Test Plan:
All scenarios use InWidth=8 and Ratio=4, giving FifoWidth=35.
1. Beats 0x11, 0x22, 0x33, 0x44 on consecutive cycles, s_last on the 4th, wr_full=0 -> exactly one wr_req pulse, one cycle after the 4th accept, with wr_data={1'b1, 2'b11, 32'h44332211}.
2. Beats 0xAA, then 0xBB with s_last, wr_full=0 -> one wr_req with wr_data={1'b1, 2'b01, 32'h0000BBAA}; the next beat lands in lane 0.
3. Continuous beats 0x01..0x08, no s_last, wr_full=0 -> s_ready stays 1; two wr_req pulses four cycles apart with wr_data={0, 2'b11, 32'h04030201} and {0, 2'b11, 32'h08070605}.
4. Word pending, then wr_full=1 for 5 cycles while s_valid=1 -> s_ready=0, wr_req=0 and wr_data stable throughout. When wr_full drops, wr_req=1 in that same cycle with the held word, and s_ready=1.
5. Beats 0x10, 0x20 accepted, then wr_rst_n pulsed low mid-cycle -> wr_req=0 and busy=0 immediately. Then 0x30, 0x40, 0x50, 0x60 with s_last on 0x60 -> wr_data={1, 2'b11, 32'h60504030}.
6. wr_full toggled randomly against a scoreboard -> no wr_req while wr_full=1; every accepted beat appears exactly once, in order, in the correct lane.
